// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_pkg
//  Brief    : Shared constants, FSM encodings and helpers for the fetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    // Canonical RV32I no-op (addi x0, x0, 0) shown before any real fetch.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Fetch FSM encodings.
    localparam logic [1:0] FETCH_BOOT  = 2'd0;
    localparam logic [1:0] FETCH_RUN   = 2'd1;
    localparam logic [1:0] FETCH_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        ST_BOOT  = FETCH_BOOT,
        ST_RUN   = FETCH_RUN,
        ST_FLUSH = FETCH_FLUSH
    } fetch_state_t;

    // Force an address onto a 32-bit word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Brief    : Small synchronous shift-register FIFO. Entry 0 is always the
//             head, so the head output comes straight from a flop.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_HEAD = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem     [DEPTH];
    logic [WIDTH-1:0] w_mem_nxt [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_wr_idx;
    logic             w_do_pop;
    logic             w_do_push;

    // A pop on an empty FIFO is ignored; a push on a full FIFO is only
    // allowed when a pop frees the slot in the same cycle.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);
    assign w_wr_idx  = w_do_pop ? (r_count - CW'(1)) : r_count;

    // Next-state contents: shift down on pop, then write at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_nxt[i] = r_mem[i];
        end
        if (w_do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_mem_nxt[i] = r_mem[i + 1];
            end
        end
        if (w_do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_idx == CW'(i)) begin
                    w_mem_nxt[i] = push_data;
                end
            end
        end
        w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);
    end

    // Storage and occupancy; flush empties the FIFO and overrides push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_HEAD;
            end
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
        end
    end

    assign count = r_count;
    assign head  = r_mem[0];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Brief    : RV32I instruction fetch unit. Sequential PC, valid/ready
//             requests to instruction memory, in-order responses buffered
//             in a FIFO and presented to decode with their PC. Redirects
//             flush buffered and in-flight words.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid_out,
    input  logic        imem_req_ready_in,
    output logic [31:0] imem_addr_out,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] w_outstanding_nxt;

    logic [CW-1:0] w_data_count;
    logic [63:0]   w_data_head;
    logic [CW-1:0] w_tag_count;
    logic [31:0]   w_tag_head;

    logic          w_redirect;
    logic          w_pop;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_rsp_fire;
    logic          w_accept_rsp;
    logic          w_push_tag;
    logic [CW:0]   w_occupancy;

    // Redirects are ignored during the single BOOT cycle.
    assign w_redirect = redirect_in && (r_state != ST_BOOT);

    assign instr_valid_out = (w_data_count != '0);
    assign w_pop           = instr_valid_out && instr_ready_in;

    // Slots in use once this cycle's pop retires. Counting the pop lets a
    // 1-cycle memory sustain one word per cycle at DEPTH=2; the pop is
    // committed at the edge, so a request raised on its credit stays valid.
    assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_data_count} - (CW+1)'(w_pop);

    assign w_req_fire = w_req_valid && imem_req_ready_in;

    // A response with nothing outstanding is a protocol error and is dropped.
    assign w_rsp_fire = imem_rvalid_in && (r_outstanding != '0);

    // Only responses to live (non-stale) requests reach the data FIFO.
    assign w_accept_rsp = w_rsp_fire && (r_state == ST_RUN) && !w_redirect
                          && (w_tag_count != '0);

    // A request accepted alongside a redirect is stale: no tag is kept.
    assign w_push_tag = w_req_fire && !w_redirect;

    // Outstanding count including this cycle's request and response.
    assign w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);

    // Next-state, fetch PC and request-valid logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_valid    = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_req_valid = (w_occupancy < (CW+1)'(DEPTH));
                if (w_redirect) begin
                    w_state_nxt = (w_outstanding_nxt != '0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (w_outstanding_nxt == '0) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        if (w_redirect) begin
            w_fetch_pc_nxt = align_word(redirect_pc_in);
        end else if (w_req_fire) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
    end

    // State, fetch PC and outstanding-request registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_fetch_pc    <= align_word(RESET_PC);
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
        end
    end

    assign imem_req_valid_out = w_req_valid;
    assign imem_addr_out      = r_fetch_pc;

    // PC tags of live requests, in issue order, paired with responses.
    fetch_fifo #(
        .WIDTH      (32),
        .DEPTH      (DEPTH),
        .RESET_HEAD (32'h0000_0000)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push_tag),
        .push_data (r_fetch_pc),
        .pop       (w_accept_rsp),
        .flush     (w_redirect),
        .count     (w_tag_count),
        .head      (w_tag_head)
    );

    // Buffered {pc, instr} words waiting for decode.
    fetch_fifo #(
        .WIDTH      (64),
        .DEPTH      (DEPTH),
        .RESET_HEAD ({32'h0000_0000, INSTR_NOP})
    ) u_data_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_accept_rsp),
        .push_data ({w_tag_head, imem_rdata_in}),
        .pop       (w_pop),
        .flush     (w_redirect),
        .count     (w_data_count),
        .head      (w_data_head)
    );

    assign instr_out = w_data_head[31:0];
    assign pc_out    = w_data_head[63:32];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Brief    : Directed self-checking bench for instr_fetch with an in-order
//             instruction memory model (data word = address ^ KEY).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] KEY      = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid_out;
    logic        imem_req_ready_in;
    logic [31:0] imem_addr_out;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_addr_out      (imem_addr_out),
        .imem_rvalid_in     (imem_rvalid_in),
        .imem_rdata_in      (imem_rdata_in),
        .redirect_in        (redirect_in),
        .redirect_pc_in     (redirect_pc_in),
        .instr_valid_out    (instr_valid_out),
        .instr_ready_in     (instr_ready_in),
        .instr_out          (instr_out),
        .pc_out             (pc_out)
    );

    // ---------------- memory model and monitors ----------------
    int          cyc        = 0;
    bit          mem_random = 1'b0;
    bit          mem_accept = 1'b1;
    int          mem_lat    = 1;
    logic [31:0] last_req_addr = 32'h0;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] req_log [$];
    logic [31:0] pop_pc  [$];
    logic [31:0] pop_ins [$];
    int          pop_cyc [$];

    // Edge-time bookkeeping: accepted requests, consumed responses, pops.
    always @(posedge clk) begin
        int lat;
        cyc = cyc + 1;
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (imem_rvalid_in) begin
                assert (mq_addr.size() > 0);
                if (mq_addr.size() > 0) begin
                    void'(mq_addr.pop_front());
                    void'(mq_due.pop_front());
                end
            end
            if (imem_req_valid_out && imem_req_ready_in) begin
                lat = mem_random ? int'($urandom_range(1, 5)) : mem_lat;
                mq_addr.push_back(imem_addr_out);
                mq_due.push_back(cyc + lat - 1);
                req_log.push_back(imem_addr_out);
                last_req_addr = imem_addr_out;
            end
            if (instr_valid_out && instr_ready_in) begin
                pop_pc.push_back(pc_out);
                pop_ins.push_back(instr_out);
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Mid-cycle drive of the memory side for the coming edge.
    always @(negedge clk) begin
        imem_req_ready_in = mem_random ? 1'($urandom_range(0, 1)) : mem_accept;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid_in = 1'b1;
            imem_rdata_in  = mq_addr[0] ^ KEY;
        end else begin
            imem_rvalid_in = 1'b0;
            imem_rdata_in  = 32'hDEAD_BEEF;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first;
        rst_n = 1'b0; instr_ready_in = 1'b1; redirect_in = 1'b0; redirect_pc_in = '0;
        mem_accept = 1'b1; mem_lat = 1; mem_random = 1'b0;
        repeat (3) tick();
        n_checks++; if (imem_req_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid_out); end
        n_checks++; if (imem_addr_out !== 32'h100) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000100", imem_addr_out); end
        n_checks++; if (instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid_out); end
        n_checks++; if (instr_out !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000013", instr_out); end
        n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", pc_out); end
        rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 10 && first == 0; i++) begin
            tick();
            if (i == 1) begin
                n_checks++;
                if (imem_req_valid_out !== 1'b1 || imem_addr_out !== 32'h100) begin
                    n_fail++; $display("FAIL first_request: got valid=%b addr=%h expected valid=1 addr=00000100", imem_req_valid_out, imem_addr_out);
                end
            end
            if (instr_valid_out === 1'b1) first = i;
        end
        n_checks++; if (first != 3) begin n_fail++; $display("FAIL first_valid_latency: got %0d expected 3", first); end
    endtask

    task automatic test_run();
        logic [31:0] exp_pc [8] = '{32'h100, 32'h104, 32'h108, 32'h10C,
                                    32'h110, 32'h114, 32'h118, 32'h11C};
        repeat (10) tick();
        n_checks++;
        if (pop_pc.size() < 8) begin
            n_fail++; $display("FAIL run_count: got %0d words expected >= 8", pop_pc.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (pop_pc[k] !== exp_pc[k] || pop_ins[k] !== (exp_pc[k] ^ KEY) || pop_cyc[k] != pop_cyc[0] + k) begin
                    n_fail++; $display("FAIL run_seq[%0d]: got pc=%h instr=%h cyc=%0d expected pc=%h instr=%h cyc=%0d",
                                       k, pop_pc[k], pop_ins[k], pop_cyc[k], exp_pc[k], exp_pc[k] ^ KEY, pop_cyc[0] + k);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int          base;
        instr_ready_in = 1'b0;
        held = RESET_PC + 32'(4 * pop_pc.size());
        base = pop_pc.size();
        repeat (10) tick();
        n_checks++; if (instr_valid_out !== 1'b1 || pc_out !== held || instr_out !== (held ^ KEY)) begin
            n_fail++; $display("FAIL bp_head: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", instr_valid_out, pc_out, instr_out, held, held ^ KEY); end
        n_checks++; if (imem_req_valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_no_issue: got %b expected 0", imem_req_valid_out); end
        n_checks++; if (mq_addr.size() != 0 || last_req_addr !== held + 32'(4 * (DEPTH - 1))) begin
            n_fail++; $display("FAIL bp_buffered: got inflight=%0d last_req=%h expected inflight=0 last_req=%h", mq_addr.size(), last_req_addr, held + 32'(4 * (DEPTH - 1))); end
        n_checks++; if (pop_pc.size() != base) begin n_fail++; $display("FAIL bp_no_pop: got %0d pops expected 0", pop_pc.size() - base); end
        instr_ready_in = 1'b1;
        repeat (8) tick();
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (pop_pc.size() <= base + k || pop_pc[base + k] !== held + 32'(4 * k) || pop_ins[base + k] !== ((held + 32'(4 * k)) ^ KEY)) begin
                n_fail++; $display("FAIL bp_drain[%0d]: got pc=%h expected %h", k, (pop_pc.size() > base + k) ? pop_pc[base + k] : 32'hx, held + 32'(4 * k));
            end
        end
    endtask

    int idx_2000;

    task automatic test_redirect();
        int i;
        mem_accept = 1'b0;
        repeat (8) tick();
        n_checks++; if (instr_valid_out !== 1'b0 || mq_addr.size() != 0) begin
            n_fail++; $display("FAIL redir_setup_drain: got v=%b inflight=%0d expected v=0 inflight=0", instr_valid_out, mq_addr.size()); end
        mem_accept = 1'b1; mem_lat = 4;
        for (i = 0; i < 6 && mq_addr.size() < 2; i++) tick();
        n_checks++; if (mq_addr.size() != 2) begin n_fail++; $display("FAIL redir_setup_inflight: got %0d expected 2", mq_addr.size()); end
        redirect_in = 1'b1; redirect_pc_in = 32'h0000_2003; mem_lat = 1;
        tick();
        redirect_in = 1'b0;
        req_log.delete();
        idx_2000 = pop_pc.size();
        n_checks++; if (instr_valid_out !== 1'b0 || imem_req_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL redir_flush: got v=%b req=%b expected v=0 req=0", instr_valid_out, imem_req_valid_out); end
        for (i = 0; i < 20 && imem_req_valid_out !== 1'b1; i++) tick();
        n_checks++; if (imem_req_valid_out !== 1'b1 || imem_addr_out !== 32'h2000 || mq_addr.size() != 0) begin
            n_fail++; $display("FAIL redir_new_req: got req=%b addr=%h inflight=%0d expected req=1 addr=00002000 inflight=0", imem_req_valid_out, imem_addr_out, mq_addr.size()); end
        for (i = 0; i < 10 && instr_valid_out !== 1'b1; i++) tick();
        n_checks++; if (instr_valid_out !== 1'b1 || pc_out !== 32'h2000 || instr_out !== 32'h5A5A_2000 || pop_pc.size() != idx_2000) begin
            n_fail++; $display("FAIL redir_first_word: got v=%b pc=%h instr=%h stale_pops=%0d expected v=1 pc=00002000 instr=5a5a2000 stale_pops=0",
                               instr_valid_out, pc_out, instr_out, pop_pc.size() - idx_2000); end
    endtask

    task automatic test_collision();
        int          n;
        int          i;
        logic [31:0] popped;
        repeat (4) tick();
        n = pop_pc.size();
        popped = 32'h2000 + 32'(4 * (n - idx_2000));
        redirect_in = 1'b1; redirect_pc_in = 32'h0000_3000;
        @(negedge clk);
        n_checks++; if (imem_rvalid_in !== 1'b1 || instr_valid_out !== 1'b1 || pc_out !== popped) begin
            n_fail++; $display("FAIL coll_setup: got rvalid=%b v=%b pc=%h expected rvalid=1 v=1 pc=%h", imem_rvalid_in, instr_valid_out, pc_out, popped); end
        tick();
        redirect_in = 1'b0;
        n_checks++; if (instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL coll_empty: got v=%b expected 0", instr_valid_out); end
        n_checks++; if (pop_pc.size() != n + 1 || pop_pc[pop_pc.size() - 1] !== popped) begin
            n_fail++; $display("FAIL coll_pop_once: got pops=%0d expected pops=1 pc=%h", pop_pc.size() - n, popped); end
        for (i = 0; i < 10 && instr_valid_out !== 1'b1; i++) tick();
        n_checks++; if (pc_out !== 32'h3000 || instr_out !== 32'h5A5A_3000 || pop_pc.size() != n + 1) begin
            n_fail++; $display("FAIL coll_next_word: got pc=%h instr=%h extra_pops=%0d expected pc=00003000 instr=5a5a3000 extra_pops=0", pc_out, instr_out, pop_pc.size() - n - 1); end
    endtask

    task automatic test_wrap();
        int          base;
        logic [31:0] exp_a [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        repeat (3) tick();
        redirect_in = 1'b1; redirect_pc_in = 32'hFFFF_FFF8;
        tick();
        redirect_in = 1'b0;
        req_log.delete();
        base = pop_pc.size();
        repeat (12) tick();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (req_log.size() <= k || req_log[k] !== exp_a[k]) begin
                n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, (req_log.size() > k) ? req_log[k] : 32'hx, exp_a[k]);
            end
            n_checks++;
            if (pop_pc.size() <= base + k || pop_pc[base + k] !== exp_a[k] || pop_ins[base + k] !== (exp_a[k] ^ KEY)) begin
                n_fail++; $display("FAIL wrap_pc[%0d]: got %h expected %h", k, (pop_pc.size() > base + k) ? pop_pc[base + k] : 32'hx, exp_a[k]);
            end
        end
    endtask

    task automatic test_random_stalls();
        int          base;
        int          i;
        logic [31:0] exp_pc;
        mem_random = 1'b1;
        redirect_in = 1'b1; redirect_pc_in = 32'h0000_4000;
        tick();
        redirect_in = 1'b0;
        base = pop_pc.size();
        for (i = 0; i < 150; i++) begin
            instr_ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end
        n_checks++; if (pop_pc.size() - base < 15) begin n_fail++; $display("FAIL rand_progress: got %0d words expected >= 15", pop_pc.size() - base); end
        exp_pc = 32'h4000;
        for (int k = base; k < pop_pc.size(); k++) begin
            n_checks++;
            if (pop_pc[k] !== exp_pc || pop_ins[k] !== (exp_pc ^ KEY)) begin
                n_fail++; $display("FAIL rand_word[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", k - base, pop_pc[k], pop_ins[k], exp_pc, exp_pc ^ KEY);
            end
            exp_pc = exp_pc + 32'd4;
        end
        // Reset in the middle of traffic.
        instr_ready_in = 1'b1;
        rst_n = 1'b0;
        tick();
        n_checks++; if (imem_req_valid_out !== 1'b0 || imem_addr_out !== 32'h100 || instr_valid_out !== 1'b0 || instr_out !== 32'h13 || pc_out !== 32'h0) begin
            n_fail++; $display("FAIL midreset: got req=%b addr=%h v=%b instr=%h pc=%h expected req=0 addr=00000100 v=0 instr=00000013 pc=00000000",
                               imem_req_valid_out, imem_addr_out, instr_valid_out, instr_out, pc_out); end
        mem_random = 1'b0; mem_accept = 1'b1; mem_lat = 1;
        rst_n = 1'b1;
        for (i = 0; i < 10 && instr_valid_out !== 1'b1; i++) tick();
        n_checks++; if (instr_valid_out !== 1'b1 || pc_out !== 32'h100 || instr_out !== 32'h5A5A_0100) begin
            n_fail++; $display("FAIL midreset_restart: got v=%b pc=%h instr=%h expected v=1 pc=00000100 instr=5a5a0100", instr_valid_out, pc_out, instr_out); end
    endtask

    initial begin
        imem_req_ready_in = 1'b0;
        imem_rvalid_in    = 1'b0;
        imem_rdata_in     = 32'h0;
        test_reset();
        test_run();
        test_backpressure();
        test_redirect();
        test_collision();
        test_wrap();
        test_random_stalls();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
